// File: rtl/simple_processor_pkg.sv
// Shared types and constants for the decode/issue front end.
// func_t values equal the 4-bit opcode field, so decode is a plain cast.
package simple_processor_pkg;

  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned INSTR_WIDTH = 16;
  localparam int unsigned REG_AW      = 3;

  typedef enum logic [3:0] {
    FN_AND  = 4'd0,
    FN_OR   = 4'd1,
    FN_XOR  = 4'd2,
    FN_NOT  = 4'd3,
    FN_ADDI = 4'd4,
    FN_ADD  = 4'd5,
    FN_SUB  = 4'd6,
    FN_SLL  = 4'd7,
    FN_SLLI = 4'd8,
    FN_SLR  = 4'd9,
    FN_SLRI = 4'd10
  } func_t;

  localparam logic [3:0] LAST_LEGAL_OPCODE = 4'd10;

  function automatic logic op_is_legal(input logic [3:0] opcode);
    return opcode <= LAST_LEGAL_OPCODE;
  endfunction

endpackage

// File: rtl/reg_file.sv
// Register file: one write port, two asynchronous read ports, r0 reads zero,
// and a same-cycle write-through bypass so a reader sees the incoming value.
module reg_file
  import simple_processor_pkg::*;
#(
  parameter int unsigned DW = DATA_WIDTH,
  parameter int unsigned NR = 8
) (
  input  logic              clk_i,
  input  logic              arst_ni,
  input  logic              wb_en_i,
  input  logic [REG_AW-1:0] wb_addr_i,
  input  logic [DW-1:0]     wb_data_i,
  input  logic [REG_AW-1:0] raddr1_i,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [DW-1:0]     rdata1_o,
  output logic [DW-1:0]     rdata2_o
);

  logic [DW-1:0] regs_q [NR];

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int i = 0; i < int'(NR); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_en_i && (wb_addr_i != '0)) begin
      regs_q[wb_addr_i] <= wb_data_i;
    end
  end

  // Bypass only for nonzero addresses; r0 stays zero even when written.
  always_comb begin
    rdata1_o = '0;
    if (raddr1_i != '0) begin
      if (wb_en_i && (wb_addr_i == raddr1_i)) rdata1_o = wb_data_i;
      else                                    rdata1_o = regs_q[raddr1_i];
    end
  end

  always_comb begin
    rdata2_o = '0;
    if (raddr2_i != '0) begin
      if (wb_en_i && (wb_addr_i == raddr2_i)) rdata2_o = wb_data_i;
      else                                    rdata2_o = regs_q[raddr2_i];
    end
  end

endmodule

// File: rtl/decode_issue.sv
// Decode-and-issue stage: decodes 16-bit instructions, reads operands, and
// holds one registered issue packet for the execution unit.
module decode_issue
  import simple_processor_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8
) (
  input  logic                   clk_i,
  input  logic                   arst_ni,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  input  logic                   instr_valid_i,
  output logic                   instr_ready_o,
  output func_t                  func_o,
  output logic [DATA_WIDTH-1:0]  rs1_data_o,
  output logic [DATA_WIDTH-1:0]  rs2_data_o,
  output logic [5:0]             imm_o,
  output logic [REG_AW-1:0]      rd_addr_o,
  output logic                   issue_valid_o,
  input  logic                   issue_ready_i,
  input  logic                   wb_en_i,
  input  logic [REG_AW-1:0]      wb_addr_i,
  input  logic [DATA_WIDTH-1:0]  wb_data_i,
  output logic                   illegal_o,
  output logic [31:0]            issued_cnt_o
);

  logic [3:0]        opcode;
  logic [REG_AW-1:0] rd_addr;
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic [5:0]        imm;

  assign opcode   = instr_i[15:12];
  assign rd_addr  = instr_i[11:9];
  assign rs1_addr = instr_i[8:6];
  assign rs2_addr = instr_i[2:0];
  assign imm      = instr_i[5:0];

  logic [DATA_WIDTH-1:0] rf_rdata1;
  logic [DATA_WIDTH-1:0] rf_rdata2;

  reg_file #(
    .DW (DATA_WIDTH),
    .NR (NUM_REGS)
  ) u_reg_file (
    .clk_i     (clk_i),
    .arst_ni   (arst_ni),
    .wb_en_i   (wb_en_i),
    .wb_addr_i (wb_addr_i),
    .wb_data_i (wb_data_i),
    .raddr1_i  (rs1_addr),
    .raddr2_i  (rs2_addr),
    .rdata1_o  (rf_rdata1),
    .rdata2_o  (rf_rdata2)
  );

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // instr_ready_o depends only on the issue register and issue_ready_i,
  // never on instr_valid_i; issue_valid_o never drops without a transfer.
  logic issue_valid_q;
  logic accept;
  logic load;
  logic fire;
  logic hold;

  assign instr_ready_o = !issue_valid_q || issue_ready_i;
  assign accept        = instr_valid_i && instr_ready_o;
  assign load          = accept && op_is_legal(opcode);
  assign fire          = issue_valid_q && issue_ready_i;
  assign hold          = issue_valid_q && !issue_ready_i;

  func_t                 func_q;
  logic [DATA_WIDTH-1:0] rs1_data_q;
  logic [DATA_WIDTH-1:0] rs2_data_q;
  logic [REG_AW-1:0]     rs1_addr_q;
  logic [REG_AW-1:0]     rs2_addr_q;
  logic [REG_AW-1:0]     rd_addr_q;
  logic [5:0]            imm_q;
  logic                  illegal_q;
  logic [31:0]           issued_cnt_q;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      issue_valid_q <= 1'b0;
    end else if (load) begin
      issue_valid_q <= 1'b1;
    end else if (fire) begin
      issue_valid_q <= 1'b0;
    end
  end

  // A held packet tracks writebacks to its source registers so it never
  // issues a stale operand.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      func_q     <= FN_AND;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
      imm_q      <= '0;
    end else if (load) begin
      func_q     <= func_t'(opcode);
      rs1_data_q <= rf_rdata1;
      rs2_data_q <= rf_rdata2;
      rs1_addr_q <= rs1_addr;
      rs2_addr_q <= rs2_addr;
      rd_addr_q  <= rd_addr;
      imm_q      <= imm;
    end else if (hold && wb_en_i && (wb_addr_i != '0)) begin
      if (wb_addr_i == rs1_addr_q) rs1_data_q <= wb_data_i;
      if (wb_addr_i == rs2_addr_q) rs2_data_q <= wb_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      illegal_q    <= 1'b0;
      issued_cnt_q <= '0;
    end else begin
      illegal_q <= accept && !op_is_legal(opcode);
      if (fire) issued_cnt_q <= issued_cnt_q + 32'd1;
    end
  end

  assign func_o        = func_q;
  assign rs1_data_o    = rs1_data_q;
  assign rs2_data_o    = rs2_data_q;
  assign imm_o         = imm_q;
  assign rd_addr_o     = rd_addr_q;
  assign issue_valid_o = issue_valid_q;
  assign illegal_o     = illegal_q;
  assign issued_cnt_o  = issued_cnt_q;

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed scenarios with literal expectations plus
// a randomized run checked every cycle against a queue-based model.
module tb_decode_issue;
  import simple_processor_pkg::*;

  localparam int DW = DATA_WIDTH;

  logic          clk_i = 1'b0;
  logic          arst_ni = 1'b0;
  logic [15:0]   instr_i = '0;
  logic          instr_valid_i = 1'b0;
  logic          instr_ready_o;
  func_t         func_o;
  logic [DW-1:0] rs1_data_o;
  logic [DW-1:0] rs2_data_o;
  logic [5:0]    imm_o;
  logic [2:0]    rd_addr_o;
  logic          issue_valid_o;
  logic          issue_ready_i = 1'b1;
  logic          wb_en_i = 1'b0;
  logic [2:0]    wb_addr_i = '0;
  logic [DW-1:0] wb_data_i = '0;
  logic          illegal_o;
  logic [31:0]   issued_cnt_o;

  decode_issue dut (
    .clk_i         (clk_i),
    .arst_ni       (arst_ni),
    .instr_i       (instr_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .func_o        (func_o),
    .rs1_data_o    (rs1_data_o),
    .rs2_data_o    (rs2_data_o),
    .imm_o         (imm_o),
    .rd_addr_o     (rd_addr_o),
    .issue_valid_o (issue_valid_o),
    .issue_ready_i (issue_ready_i),
    .wb_en_i       (wb_en_i),
    .wb_addr_i     (wb_addr_i),
    .wb_data_i     (wb_data_i),
    .illegal_o     (illegal_o),
    .issued_cnt_o  (issued_cnt_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The stage is a queue of at most one pending packet; the register file is
  // a plain array. Outputs are predicted from those alone.
  typedef struct packed {
    logic [3:0]    func;
    logic [2:0]    rd;
    logic [5:0]    imm;
    logic [2:0]    a1;
    logic [2:0]    a2;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
  } pkt_t;
  localparam int PKT_W = $bits(pkt_t);

  logic [PKT_W-1:0] exp_q[$];
  logic [DW-1:0]    m_regs [8];
  logic [31:0]      m_cnt = '0;
  logic             m_illegal = 1'b0;

  function automatic logic [DW-1:0] model_read(input logic [2:0] a);
    if (a == 3'd0) return '0;
    if (wb_en_i && wb_addr_i == a) return wb_data_i;
    return m_regs[a];
  endfunction

  always @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      exp_q.delete();
      m_cnt = '0;
      m_illegal = 1'b0;
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
    end else begin
      pkt_t p;
      pkt_t np;
      logic holding;
      logic acc;
      logic [3:0] op;
      holding = exp_q.size() != 0;
      acc = instr_valid_i && (!holding || issue_ready_i);
      op = instr_i[15:12];
      m_illegal = acc && (op > 4'd10);
      np.func = op;
      np.rd   = instr_i[11:9];
      np.imm  = instr_i[5:0];
      np.a1   = instr_i[8:6];
      np.a2   = instr_i[2:0];
      np.d1   = model_read(instr_i[8:6]);
      np.d2   = model_read(instr_i[2:0]);
      if (holding && issue_ready_i) begin
        exp_q.delete(0);
        m_cnt = m_cnt + 32'd1;
      end else if (holding && wb_en_i && wb_addr_i != 3'd0) begin
        p = pkt_t'(exp_q[0]);
        if (p.a1 == wb_addr_i) p.d1 = wb_data_i;
        if (p.a2 == wb_addr_i) p.d2 = wb_data_i;
        exp_q[0] = PKT_W'(p);
      end
      if (acc && op <= 4'd10) exp_q.push_back(PKT_W'(np));
      if (wb_en_i && wb_addr_i != 3'd0) m_regs[wb_addr_i] = wb_data_i;
    end
  end

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk_i) begin
    if (arst_ni) begin
      pkt_t p;
      chk("instr_ready", 64'(instr_ready_o), 64'((exp_q.size() == 0) || issue_ready_i));
      chk("issue_valid", 64'(issue_valid_o), 64'(exp_q.size() != 0));
      chk("illegal", 64'(illegal_o), 64'(m_illegal));
      chk("issued_cnt", 64'(issued_cnt_o), 64'(m_cnt));
      if (exp_q.size() != 0) begin
        p = pkt_t'(exp_q[0]);
        chk("func", 64'(func_o), 64'(p.func));
        chk("rd_addr", 64'(rd_addr_o), 64'(p.rd));
        chk("imm", 64'(imm_o), 64'(p.imm));
        chk("rs1_data", 64'(rs1_data_o), 64'(p.d1));
        chk("rs2_data", 64'(rs2_data_o), 64'(p.d2));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic send(input logic [15:0] w);
    instr_i = w;
    instr_valid_i = 1'b1;
  endtask

  task automatic wb(input logic en, input logic [2:0] a, input logic [DW-1:0] d);
    wb_en_i = en;
    wb_addr_i = a;
    wb_data_i = d;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"}, 64'(issue_valid_o), 64'd0);
    chk({tag, "_illegal"}, 64'(illegal_o), 64'd0);
    chk({tag, "_cnt"}, 64'(issued_cnt_o), 64'd0);
    chk({tag, "_func"}, 64'(func_o), 64'(FN_AND));
    chk({tag, "_rs1"}, 64'(rs1_data_o), 64'd0);
    chk({tag, "_rs2"}, 64'(rs2_data_o), 64'd0);
    chk({tag, "_imm"}, 64'(imm_o), 64'd0);
    chk({tag, "_rd"}, 64'(rd_addr_o), 64'd0);
    chk({tag, "_ready"}, 64'(instr_ready_o), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] b2b [4];

  initial begin
    b2b[0] = 16'h1240; b2b[1] = 16'h2480; b2b[2] = 16'h36C0; b2b[3] = 16'h5AC2;
    #1;
    check_reset_values("reset");
    tick();
    arst_ni = 1'b1;

    // Load r1 = 7, r2 = 5, then ADD r3, r1, r2.
    wb(1'b1, 3'd1, 32'h7); tick();
    wb(1'b1, 3'd2, 32'h5); tick();
    wb(1'b0, 3'd0, '0);
    send(16'h5642); tick();
    instr_valid_i = 1'b0;
    chk("add_valid", 64'(issue_valid_o), 64'd1);
    chk("add_func", 64'(func_o), 64'(FN_ADD));
    chk("add_rs1", 64'(rs1_data_o), 64'h7);
    chk("add_rs2", 64'(rs2_data_o), 64'h5);
    chk("add_rd", 64'(rd_addr_o), 64'd3);
    tick();
    chk("add_cnt", 64'(issued_cnt_o), 64'd1);
    chk("add_drop", 64'(issue_valid_o), 64'd0);

    // ADDI r1, r0, 3; then r0 write is ignored.
    send(16'h4203); tick();
    instr_valid_i = 1'b0;
    chk("addi_rs1", 64'(rs1_data_o), 64'd0);
    chk("addi_imm", 64'(imm_o), 64'h03);
    wb(1'b1, 3'd0, 32'hDEADBEEF); tick();
    wb(1'b0, 3'd0, '0);
    send(16'h0000); tick();
    chk("r0_rs1", 64'(rs1_data_o), 64'd0);
    chk("r0_rs2", 64'(rs2_data_o), 64'd0);

    // Illegal opcode: consumed, one-cycle pulse, no issue.
    send(16'hF000); tick();
    instr_valid_i = 1'b0;
    chk("ill_pulse", 64'(illegal_o), 64'd1);
    chk("ill_valid", 64'(issue_valid_o), 64'd0);
    chk("ill_cnt", 64'(issued_cnt_o), 64'd3);
    tick();
    chk("ill_pulse_end", 64'(illegal_o), 64'd0);
    chk("ill_cnt_hold", 64'(issued_cnt_o), 64'd3);

    // Hold with execution stalled; writeback updates the held operand.
    issue_ready_i = 1'b0;
    send(16'h1050); tick();
    chk("hold_ready", 64'(instr_ready_o), 64'd0);
    chk("hold_rs1", 64'(rs1_data_o), 64'h7);
    send(16'h2000);
    wb(1'b1, 3'd1, 32'hA5A5A5A5); tick();
    wb(1'b0, 3'd0, '0);
    chk("held_update", 64'(rs1_data_o), 64'hA5A5A5A5);
    chk("held_valid", 64'(issue_valid_o), 64'd1);
    chk("held_cnt", 64'(issued_cnt_o), 64'd3);
    instr_valid_i = 1'b0;
    issue_ready_i = 1'b1;
    tick();
    chk("release_valid", 64'(issue_valid_o), 64'd0);
    chk("release_cnt", 64'(issued_cnt_o), 64'd4);

    // Back-to-back; last one bypasses a same-cycle writeback to r3.
    for (int i = 0; i < 4; i++) begin
      send(b2b[i]);
      if (i == 3) wb(1'b1, 3'd3, 32'h12345678);
      tick();
      chk("b2b_valid", 64'(issue_valid_o), 64'd1);
    end
    wb(1'b0, 3'd0, '0);
    instr_valid_i = 1'b0;
    chk("bypass_rs1", 64'(rs1_data_o), 64'h12345678);
    chk("bypass_rs2", 64'(rs2_data_o), 64'h5);
    tick();
    chk("b2b_cnt", 64'(issued_cnt_o), 64'd8);
    chk("b2b_drop", 64'(issue_valid_o), 64'd0);

    // Reset while a packet is held.
    issue_ready_i = 1'b0;
    send(16'h5642); tick();
    instr_valid_i = 1'b0;
    chk("pre_rst_valid", 64'(issue_valid_o), 64'd1);
    arst_ni = 1'b0;
    #1;
    check_reset_values("midrst");
    tick();
    arst_ni = 1'b1;
    issue_ready_i = 1'b1;
    send(16'h5642); tick();
    instr_valid_i = 1'b0;
    chk("post_rst_valid", 64'(issue_valid_o), 64'd1);
    chk("post_rst_func", 64'(func_o), 64'(FN_ADD));
    chk("post_rst_rs1", 64'(rs1_data_o), 64'd0);
    chk("post_rst_rd", 64'(rd_addr_o), 64'd3);
    chk("post_rst_cnt", 64'(issued_cnt_o), 64'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      instr_valid_i = $urandom_range(0, 3) != 0;
      instr_i       = 16'($urandom);
      issue_ready_i = $urandom_range(0, 9) < 7;
      wb_en_i       = $urandom_range(0, 1) == 1;
      wb_addr_i     = 3'($urandom_range(0, 7));
      wb_data_i     = $urandom;
      if ($urandom_range(0, 799) == 0) begin
        arst_ni = 1'b0;
        #1;
        arst_ni = 1'b1;
      end
      tick();
    end
    instr_valid_i = 1'b0;
    wb_en_i = 1'b0;
    issue_ready_i = 1'b1;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_issue.md
# decode_issue

Decode-and-issue stage that feeds the execution unit. Accepts 16-bit instruction words over a valid/ready handshake, decodes them into `func_t`/operand fields, and reads operands from an internal 8-entry register file. It presents one registered issue packet to execution and takes execution results back through a writeback port. It sits between instruction fetch and `merge_execution`, and is the producing end of that block's operand interface.

## Interface
- `DATA_WIDTH`, package default (32): operand/register width
- `NUM_REGS`, 8: register count (address width 3)
- `clk_i`  in  1  clock, rising edge
- `arst_ni`  in  1  reset, asynchronous, active-low
- `instr_i`  in  16  instruction word
- `instr_valid_i`  in  1  instruction valid
- `instr_ready_o`  out  1  stage can accept an instruction
- `func_o`  out  `func_t`  decoded operation
- `rs1_data_o` / `rs2_data_o`  out  DATA_WIDTH  operands
- `imm_o`  out  6  raw immediate; execution sign-extends it
- `rd_addr_o`  out  3  destination register
- `issue_valid_o`  out  1  issue packet valid
- `issue_ready_i`  in  1  execution accepts the packet
- `wb_en_i`  in  1  writeback enable
- `wb_addr_i`  in  3  writeback register
- `wb_data_i`  in  DATA_WIDTH  writeback data
- `illegal_o`  out  1  one-cycle pulse when an illegal opcode is consumed
- `issued_cnt_o`  out  32  count of issued packets

## Operation
- Instruction format:
  - [15:12] opcode
  - [11:9] rd
  - [8:6] rs1
  - [5:0] imm
  - rs2 = instr[2:0]
- Opcode encoding: 0..10 map to AND, OR, XOR, NOT, ADDI, ADD, SUB, SLL, SLLI, SLR, SLRI. The `func_t` enum values in the package equal these codes.
- Opcodes 11..15 are illegal:
  - The instruction is consumed (handshake completes) but not issued.
  - `illegal_o` pulses high on the next cycle.
  - Counter and issue register are unchanged.
- Register file: NUM_REGS × DATA_WIDTH flops, all reset to 0.
  - r0 always reads 0; writes to r0 are ignored.
  - Write occurs on any cycle with `wb_en_i`.
- Read bypass: if `wb_en_i` and `wb_addr_i` equal rs1 or rs2 (nonzero) in the accept cycle, that operand takes `wb_data_i`.
- Held-operand update: while `issue_valid_o && !issue_ready_i`, a writeback whose address matches the held rs1/rs2 address (nonzero) overwrites the held operand on that edge. The stored rs1/rs2 addresses are kept internally for this.
- `issued_cnt_o` increments by 1 on each cycle with `issue_valid_o && issue_ready_i`. It wraps from 0xFFFFFFFF to 0.

## Timing
- Accept occurs when `instr_valid_i && instr_ready_o`.
- `instr_ready_o = !issue_valid_o || issue_ready_i`. This is combinational, gives full throughput, and never depends on `instr_valid_i`.
- Latency: a legal instruction accepted at edge N is visible on the issue outputs after edge N with `issue_valid_o = 1`.
- Output register behaviour:
  - Issue outputs are stable while `issue_valid_o && !issue_ready_i`, except for the held-operand update above.
  - `issue_valid_o` falls after a handshake cycle with no new legal accept.
  - Simultaneous handshake and accept loads the new packet; the valid bit stays 1.
- Reset values: `issue_valid_o`, `illegal_o`, `issued_cnt_o` are 0; `func_o` is AND; data, imm and rd outputs are 0; `instr_ready_o` is 1; all registers are 0.
- Reset mid-operation drops any held packet immediately (asynchronous); no partial issue.
- Writeback and read of the same register in one cycle: the new value is used (bypass), and the regfile is also written.

## Structure
- `simple_processor_pkg` holds `DATA_WIDTH`, `func_t` (with the explicit encoding above), and `INSTR_WIDTH = 16`.
- `func_t` is also used by the decode field extraction.
- One sub-module: `reg_file` (NUM_REGS × DATA_WIDTH). It has the write port, two async read ports, r0 hardwired to zero, and built-in write-through bypass.
- Decode logic, the issue register, held-operand update and the counter live in `decode_issue`.

## Test plan
- Reset, `issue_ready_i = 1`: write r1 = 0x00000007 and r2 = 0x00000005 via wb. Send 0x5642 (ADD r3, r1, r2) → next cycle `func_o` = ADD, rs1 = 7, rs2 = 5, `rd_addr_o` = 3, `issued_cnt_o` = 1.
- Send 0x4203 (ADDI r1, r0, 3) → rs1 = 0, `imm_o` = 0x03. Writeback to r0 with 0xDEADBEEF, then read r0 → 0.
- Send 0xF000 → `illegal_o` high for exactly one cycle, `issue_valid_o` stays 0, counter unchanged.
- Hold `issue_ready_i = 0` with a packet held. Then:
  - `instr_ready_o` must be 0.
  - Writeback r1 = 0xA5A5A5A5 → held `rs1_data_o` becomes 0xA5A5A5A5 next cycle.
  - Raising ready issues exactly one packet.
- Back-to-back accepts of 4 instructions with ready held high → 4 consecutive valid cycles, count = 4. Same-cycle wb to rs1 → bypassed value is issued.
- Assert `arst_ni` low while a packet is held → outputs return to reset values immediately. After release, the first instruction issues normally.
